rv32i_mc_core: RTL and testbench

- Multi-cycle RV32I integer core: the processor of the computer top level.
- Fetches instructions over a read-only Avalon-MM host port (instruction manager).
- Performs loads/stores over a read/write Avalon-MM host port (data manager). Both ports attach to a dual-ported RAM.
- Exposes the current PC and instruction for debug/waveform use.

---
 rtl/rv32i_mc_core.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_rv32i_mc_core.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_core.sv
// rv32i_mc_core: multi-cycle RV32I integer core.
// Sequence per instruction: FETCH -> EXEC -> (MEM) -> WB, with HALT on
// ECALL/EBREAK, illegal encodings and misaligned accesses or jump targets.
// Instruction and data traffic use two Avalon-MM host ports.
// Optional macro DUMP_STATE_EN adds a simulation-only dump_state task and a
// "retire pc=<hex> insn=<hex>" print in every WB cycle.
module rv32i_mc_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] i_address,
    output logic        i_read,
    input  logic [31:0] i_readdata,
    input  logic        i_waitrequest,
    output logic [31:0] d_address,
    output logic        d_read,
    output logic        d_write,
    output logic [3:0]  d_byteenable,
    output logic [31:0] d_writedata,
    input  logic [31:0] d_readdata,
    input  logic        d_waitrequest,
    output logic [31:0] debug_current_pc,
    output logic [31:0] debug_instruction,
    output logic        halted
);
    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    state_t          state, next_state;
    logic [31:0]     pc, ir, res, npc, maddr, wdata_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] rf [32];

    // Instruction fields and immediates
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1_a, rs2_a;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1_a  = ir[19:15];
    assign rs2_a  = ir[24:20];
    assign f7     = ir[31:25];
    // rf[0] is never written, so x0 always reads zero.
    assign rs1    = rf[rs1_a];
    assign rs2    = rf[rs2_a];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'h000};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // Shared ALU for OP and OP-IMM; alt selects SUB / SRA.
    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] fn, input logic alt);
        logic [4:0]  sh;
        logic [31:0] r;
        sh = b[4:0];
        case (fn)
            3'b000: begin
                if (alt) r = a - b;
                else     r = a + b;
            end
            3'b001: r = a << sh;
            3'b010: r = {31'd0, ($signed(a) < $signed(b))};
            3'b011: r = {31'd0, (a < b)};
            3'b100: r = a ^ b;
            3'b101: begin
                if (alt) r = $unsigned($signed(a) >>> sh);
                else     r = a >> sh;
            end
            3'b110: r = a | b;
            3'b111: r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    logic [31:0] ex_res, ex_npc, ex_addr, ex_wdata;
    logic [3:0]  ex_be;
    logic        ex_illegal, ex_misal, ex_mem, ex_take;

    // Decode and execute the latched instruction in a single cycle
    always_comb begin
        ex_res     = 32'd0;
        ex_npc     = pc + 32'd4;
        ex_addr    = 32'd0;
        ex_illegal = 1'b0;
        ex_mem     = 1'b0;
        ex_take    = 1'b0;
        case (opcode)
            OP_LUI:   ex_res = imm_u;
            OP_AUIPC: ex_res = pc + imm_u;
            OP_JAL: begin
                ex_res = pc + 32'd4;
                ex_npc = pc + imm_j;
            end
            OP_JALR: begin
                ex_res     = pc + 32'd4;
                ex_npc     = (rs1 + imm_i) & 32'hFFFF_FFFE;
                ex_illegal = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                case (f3)
                    3'b000:  ex_take = (rs1 == rs2);
                    3'b001:  ex_take = (rs1 != rs2);
                    3'b100:  ex_take = ($signed(rs1) < $signed(rs2));
                    3'b101:  ex_take = ($signed(rs1) >= $signed(rs2));
                    3'b110:  ex_take = (rs1 < rs2);
                    3'b111:  ex_take = (rs1 >= rs2);
                    default: ex_illegal = 1'b1;
                endcase
                if (ex_take) ex_npc = pc + imm_b;
                else         ex_npc = pc + 32'd4;
            end
            OP_LOAD: begin
                ex_mem     = 1'b1;
                ex_addr    = rs1 + imm_i;
                ex_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                ex_mem     = 1'b1;
                ex_addr    = rs1 + imm_s;
                ex_illegal = f3[2] || (f3[1:0] == 2'b11);
            end
            OP_IMM: begin
                ex_res     = alu(rs1, imm_i, f3, (f3 == 3'b101) && ir[30]);
                ex_illegal = ((f3 == 3'b001) && (f7 != 7'd0)) ||
                             ((f3 == 3'b101) && (f7 != 7'd0) && (f7 != 7'b0100000));
            end
            OP_REG: begin
                ex_res     = alu(rs1, rs2, f3, ir[30]);
                ex_illegal = (f7 != 7'd0) &&
                             !((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OP_FENCE: ex_res = 32'd0;
            default:  ex_illegal = 1'b1;
        endcase
        // Lane enables and replicated store data by access size
        case (f3[1:0])
            2'b00: begin
                ex_be    = 4'b0001 << ex_addr[1:0];
                ex_wdata = {4{rs2[7:0]}};
            end
            2'b01: begin
                ex_be    = 4'b0011 << {ex_addr[1], 1'b0};
                ex_wdata = {2{rs2[15:0]}};
            end
            default: begin
                ex_be    = 4'b1111;
                ex_wdata = rs2;
            end
        endcase
        // Non-jump instructions leave ex_npc = pc+4, which is always aligned
        ex_misal = ex_npc[1] ||
                   (ex_mem && (((f3[1:0] == 2'b01) && ex_addr[0]) ||
                               ((f3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00))));
    end

    // Load data: bring the addressed lane down to bit 0 and extend
    logic [31:0] ld_shift, ld_val;
    assign ld_shift = d_readdata >> {maddr[1:0], 3'b000};

    // Sign or zero extension of the loaded byte/halfword
    always_comb begin
        case (f3)
            3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_val = {24'd0, ld_shift[7:0]};
            3'b101:  ld_val = {16'd0, ld_shift[15:0]};
            default: ld_val = ld_shift;
        endcase
    end

    logic wr_en;
    assign wr_en = (rd != 5'd0) && (opcode != OP_STORE) && (opcode != OP_BRANCH) &&
                   (opcode != OP_FENCE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    // Next state and bus requests; requests are forced low while rst is high
    always_comb begin
        next_state = state;
        i_read     = 1'b0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        case (state)
            FETCH: begin
                i_read = ~rst;
                if (!i_waitrequest) next_state = EXEC;
                else                next_state = FETCH;
            end
            EXEC: begin
                if (ex_illegal || ex_misal) next_state = HALT;
                else if (ex_mem)            next_state = MEM;
                else                        next_state = WB;
            end
            MEM: begin
                d_read  = ~rst && (opcode == OP_LOAD);
                d_write = ~rst && (opcode == OP_STORE);
                if (!d_waitrequest) next_state = WB;
                else                next_state = MEM;
            end
            WB:      next_state = FETCH;
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    // Datapath registers: PC, instruction, result, memory access, register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            ir      <= 32'd0;
            res     <= 32'd0;
            npc     <= 32'd0;
            maddr   <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            for (int k = 0; k < 32; k++) rf[k] <= {XLEN{1'b0}};
        end else begin
            case (state)
                FETCH: if (!i_waitrequest) ir <= i_readdata;
                EXEC: begin
                    res     <= ex_res;
                    npc     <= ex_npc;
                    maddr   <= ex_addr;
                    be_q    <= ex_be;
                    wdata_q <= ex_wdata;
                end
                MEM: if (!d_waitrequest && (opcode == OP_LOAD)) res <= ld_val;
                WB: begin
                    if (wr_en) rf[rd] <= res;
                    pc <= npc;
                end
                default: pc <= pc;
            endcase
        end
    end

    assign i_address         = pc;
    assign d_address         = {maddr[31:2], 2'b00};
    assign d_byteenable      = be_q;
    assign d_writedata       = wdata_q;
    assign halted            = (state == HALT);
    assign debug_current_pc  = rst ? 32'd0 : pc;
    assign debug_instruction = rst ? 32'd0 : ir;

`ifdef DUMP_STATE_EN
    task automatic dump_state();
        $display("pc=%h state=%0d", pc, state);
        for (int k = 0; k < 32; k++) $display("x%0d=%h", k, rf[k]);
    endtask

    // Trace every retiring instruction
    always @(posedge clk) begin
        if (!rst && state == WB) $display("retire pc=%h insn=%h", pc, ir);
    end
`endif

endmodule

// File: tb/tb_rv32i_mc_core.sv
// Directed testbench for rv32i_mc_core: small hand-assembled programs run from
// a dual-ported word memory; results checked against hand-computed values.
module tb_rv32i_mc_core;
    localparam logic [6:0]  OPIMM  = 7'b0010011;
    localparam logic [6:0]  LOAD   = 7'b0000011;
    localparam logic [6:0]  LUI    = 7'b0110111;
    localparam logic [6:0]  AUIPC  = 7'b0010111;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_address, i_readdata, d_address, d_writedata, d_readdata;
    logic [31:0] debug_current_pc, debug_instruction;
    logic        i_read, i_waitrequest, d_read, d_write, d_waitrequest, halted;
    logic [3:0]  d_byteenable;

    logic [31:0] mem  [256];
    logic [31:0] prog [256];
    int          i_stall, i_stall_init;
    logic        d_wait;
    int          cyc;
    logic [31:0] fa[$];
    int          fc[$];
    logic [31:0] da[$];
    logic [3:0]  dbe[$];
    logic [31:0] dwd[$];
    logic        dwr[$];
    logic        d_read_seen;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    rv32i_mc_core dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_readdata(i_readdata),
        .i_waitrequest(i_waitrequest),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_byteenable(d_byteenable), .d_writedata(d_writedata),
        .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
        .debug_current_pc(debug_current_pc), .debug_instruction(debug_instruction),
        .halted(halted)
    );

    assign i_waitrequest = (i_stall != 0);
    assign d_waitrequest = d_wait;
    assign i_readdata    = mem[i_address[9:2]];
    assign d_readdata    = mem[d_address[9:2]];

    // Memory model: reloads the program during reset, applies byte-lane writes
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) mem[k] <= prog[k];
            i_stall <= i_stall_init;
        end else begin
            if (i_read && i_stall != 0) i_stall <= i_stall - 1;
            if (d_write && !d_waitrequest)
                for (int b = 0; b < 4; b++)
                    if (d_byteenable[b]) mem[d_address[9:2]][8*b +: 8] <= d_writedata[8*b +: 8];
        end
    end

    // Cycle counter since reset release
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Transfer log, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            fa.delete(); fc.delete(); da.delete(); dbe.delete(); dwd.delete(); dwr.delete();
            d_read_seen <= 1'b0;
        end else begin
            if (i_read && !i_waitrequest) begin
                fa.push_back(i_address);
                fc.push_back(cyc + 1);
            end
            if ((d_read || d_write) && !d_waitrequest) begin
                da.push_back(d_address);
                dbe.push_back(d_byteenable);
                dwd.push_back(d_writedata);
                dwr.push_back(d_write);
            end
            if (d_read) d_read_seen <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] i_t(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] s_t(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_t(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] j_t(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] u_t(input logic [31:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
        return {imm[19:0], rd, op};
    endfunction
    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic clear_prog();
        for (int k = 0; k < 256; k++) prog[k] = 32'd0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold reset two cycles, check reset outputs, then release just after an edge
    task automatic start_prog();
        rst = 1'b1;
        step(2);
        chk("rst_i_read", {31'd0, i_read}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_dbg_pc", debug_current_pc, 32'd0);
        chk("rst_dbg_insn", debug_instruction, 32'd0);
        rst = 1'b0;
        #1;
        chk("first_fetch_req", {31'd0, i_read}, 32'd1);
        chk("first_fetch_addr", i_address, 32'd0);
    endtask

    task automatic run_to_halt(input int maxc);
        int k;
        k = 0;
        while (!halted && k < maxc) begin
            step(1);
            k++;
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        logic [31:0] expf [8];
        i_stall_init = 0;
        d_wait       = 1'b0;

        // ---- ALU, store and sign/zero-extending byte loads ----
        clear_prog();
        prog[0] = i_t(32'd5, 5'd0, 3'd0, 5'd1, OPIMM);          // ADDI x1,x0,5
        prog[1] = i_t(32'hFFFF_FFF9, 5'd1, 3'd0, 5'd2, OPIMM);  // ADDI x2,x1,-7
        prog[2] = s_t(32'h100, 5'd2, 5'd0, 3'b010);              // SW x2,0x100(x0)
        prog[3] = i_t(32'h101, 5'd0, 3'b000, 5'd3, LOAD);        // LB x3,0x101(x0)
        prog[4] = i_t(32'h101, 5'd0, 3'b100, 5'd4, LOAD);        // LBU x4,0x101(x0)
        prog[5] = EBREAK;
        start_prog();
        run_to_halt(200);
        chk("fetch_count", 32'(fa.size()), 32'd6);
        if (fa.size() >= 2) begin
            chk("fetch0_cycle", 32'(fc[0]), 32'd1);
            chk("fetch1_addr", fa[1], 32'h4);
            chk("fetch1_cycle", 32'(fc[1]), 32'd4);
        end
        chk("x1", dut.rf[1], 32'h0000_0005);
        chk("x2", dut.rf[2], 32'hFFFF_FFFE);
        chk("x3", dut.rf[3], 32'hFFFF_FFFF);
        chk("x4", dut.rf[4], 32'h0000_00FF);
        chk("mem_0x100", mem[64], 32'hFFFF_FFFE);
        chk("dxfer_count", 32'(da.size()), 32'd3);
        if (da.size() >= 3) begin
            chk("sw_write", {31'd0, dwr[0]}, 32'd1);
            chk("sw_addr", da[0], 32'h100);
            chk("sw_be", {28'd0, dbe[0]}, 32'hF);
            chk("sw_data", dwd[0], 32'hFFFF_FFFE);
            chk("lb_write", {31'd0, dwr[1]}, 32'd0);
            chk("lb_addr", da[1], 32'h100);
            chk("lb_be", {28'd0, dbe[1]}, 32'h2);
            chk("lbu_be", {28'd0, dbe[2]}, 32'h2);
        end
        chk("ebreak_pc", debug_current_pc, 32'h14);
        chk("ebreak_insn", debug_instruction, EBREAK);
        step(5);
        chk("halt_pc_frozen", debug_current_pc, 32'h14);
        chk("halt_no_fetch", {31'd0, i_read}, 32'd0);
        chk("halt_held", {31'd0, halted}, 32'd1);

        // ---- Branches and JAL ----
        clear_prog();
        for (int k = 0; k < 4; k++) prog[k] = NOP;
        prog[4]  = b_t(32'd8, 5'd0, 5'd0, 3'b000);   // 0x10 BEQ x0,x0,+8
        prog[6]  = j_t(32'h20, 5'd1);                // 0x18 JAL x1,+0x20
        prog[14] = b_t(32'd8, 5'd0, 5'd0, 3'b001);   // 0x38 BNE x0,x0,+8
        prog[15] = EBREAK;                           // 0x3C
        start_prog();
        run_to_halt(200);
        expf = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h18, 32'h38, 32'h3C};
        chk("br_fetch_count", 32'(fa.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            if (k < fa.size()) chk($sformatf("br_fetch%0d", k), fa[k], expf[k]);
        chk("jal_link", dut.rf[1], 32'h0000_001C);

        // ---- Shifts, compares, LUI/AUIPC/SUB, then misaligned LW ----
        clear_prog();
        prog[0] = i_t(32'hFFFF_FFF0, 5'd0, 3'b000, 5'd1, OPIMM);  // ADDI x1,x0,-16
        prog[1] = i_t(32'h402, 5'd1, 3'b101, 5'd2, OPIMM);        // SRAI x2,x1,2
        prog[2] = i_t(32'd28, 5'd1, 3'b101, 5'd3, OPIMM);         // SRLI x3,x1,28
        prog[3] = i_t(32'd0, 5'd1, 3'b010, 5'd4, OPIMM);          // SLTI x4,x1,0
        prog[4] = i_t(32'd1, 5'd1, 3'b011, 5'd5, OPIMM);          // SLTIU x5,x1,1
        prog[5] = u_t(32'h12345, 5'd6, LUI);                      // LUI x6,0x12345
        prog[6] = r_t(7'b0100000, 5'd1, 5'd6, 3'b000, 5'd7);      // SUB x7,x6,x1
        prog[7] = u_t(32'h1, 5'd8, AUIPC);                        // AUIPC x8,1 @0x1C
        prog[8] = i_t(32'h77, 5'd0, 3'b000, 5'd9, OPIMM);         // ADDI x9,x0,0x77
        prog[9] = i_t(32'h102, 5'd0, 3'b010, 5'd9, LOAD);         // LW x9,0x102(x0)
        start_prog();
        run_to_halt(200);
        chk("srai", dut.rf[2], 32'hFFFF_FFFC);
        chk("srli", dut.rf[3], 32'h0000_000F);
        chk("slti", dut.rf[4], 32'h0000_0001);
        chk("sltiu", dut.rf[5], 32'h0000_0000);
        chk("lui", dut.rf[6], 32'h1234_5000);
        chk("sub", dut.rf[7], 32'h1234_5010);
        chk("auipc", dut.rf[8], 32'h0000_101C);
        chk("misal_rd_kept", dut.rf[9], 32'h0000_0077);
        chk("misal_pc", debug_current_pc, 32'h24);
        chk("misal_no_dread", {31'd0, d_read_seen}, 32'd0);
        chk("misal_no_xfer", 32'(da.size()), 32'd0);

        // ---- Fetch stalled three cycles ----
        clear_prog();
        prog[0] = i_t(32'd5, 5'd0, 3'd0, 5'd1, OPIMM);
        prog[1] = i_t(32'hFFFF_FFF9, 5'd1, 3'd0, 5'd2, OPIMM);
        prog[2] = EBREAK;
        i_stall_init = 3;
        start_prog();
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("stall_req_c%0d", k), {31'd0, i_read}, 32'd1);
            chk($sformatf("stall_addr_c%0d", k), i_address, 32'h0);
            chk($sformatf("stall_insn_c%0d", k), debug_instruction, 32'd0);
            step(1);
        end
        chk("stall_latched", debug_instruction, prog[0]);
        run_to_halt(200);
        if (fa.size() >= 2) begin
            chk("stall_fetch1_addr", fa[1], 32'h4);
            chk("stall_fetch1_cycle", 32'(fc[1]), 32'd7);
        end else begin
            chk("stall_fetch_count", 32'(fa.size()), 32'd3);
        end
        chk("stall_x2", dut.rf[2], 32'hFFFF_FFFE);
        i_stall_init = 0;

        // ---- Reset during a stalled store ----
        clear_prog();
        prog[0] = i_t(32'd9, 5'd0, 3'd0, 5'd5, OPIMM);   // ADDI x5,x0,9
        prog[1] = s_t(32'd0, 5'd5, 5'd0, 3'b010);        // SW x5,0(x0)
        d_wait = 1'b1;
        start_prog();
        for (int k = 0; k < 20 && !d_write; k++) step(1);
        chk("stalled_dwrite", {31'd0, d_write}, 32'd1);
        chk("pre_rst_x5", dut.rf[5], 32'h0000_0009);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_drops_dwrite", {31'd0, d_write}, 32'd0);
        chk("rst_drops_iread", {31'd0, i_read}, 32'd0);
        chk("rst_dbg_pc_mid", debug_current_pc, 32'd0);
        step(1);
        d_wait = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_pc", debug_current_pc, 32'h0);
        chk("post_rst_x5", dut.rf[5], 32'h0);
        chk("post_rst_fetch", {31'd0, i_read}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
